// File: rtl/joybus_pkg.sv
// Joybus console->controller receiver: shared constants, state encoding and helpers.
package joybus_pkg;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [7:0] CRC8_POLY = 8'h85;

    // index i covers address bit i+5
    localparam logic [4:0] ADDR_CHK_TABLE [10:0] = '{
        5'h01, 5'h1A, 5'h0D, 5'h1C, 5'h0E, 5'h07,
        5'h19, 5'h16, 5'h0B, 5'h1F, 5'h15
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT_LOW,
        ST_BIT_WAIT,
        ST_STOP,
        ST_DRAIN
    } rx_state_e;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

    function automatic logic addr_chk_ok(input logic [15:0] a);
        logic [4:0] x;
        x = '0;
        for (int i = 0; i < 11; i++)
            if (a[i+5]) x = x ^ ADDR_CHK_TABLE[i];
        return x == a[4:0];
    endfunction

endpackage

// File: rtl/joybus_cmd_rx_if.sv
// Line input, enable and decoded-frame outputs of the Joybus receiver.
interface joybus_cmd_rx_if;

    logic        rx_enable;
    logic        data_rx;
    logic [7:0]  cmd;
    logic [15:0] address;
    logic        addr_ok;
    logic [7:0]  data_byte;
    logic        data_valid;
    logic [7:0]  data_crc;
    logic        tx_handoff;
    logic        frame_error;

    modport master (
        input  rx_enable, data_rx,
        output cmd, address, addr_ok, data_byte, data_valid,
        output data_crc, tx_handoff, frame_error
    );

    modport slave (
        output rx_enable, data_rx,
        input  cmd, address, addr_ok, data_byte, data_valid,
        input  data_crc, tx_handoff, frame_error
    );

endinterface

// File: rtl/joybus_crc8.sv
// Bit-serial CRC-8 over the WRITE payload, MSB first.
module joybus_crc8
    import joybus_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    input  logic       augment,
    output logic [7:0] crc
);

    logic [7:0] state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    state <= '0;
        else if (clear)  state <= '0;
        else if (enable) state <= crc8_step(state, bit_in);
    end

    // augmented view: eight trailing zero bits pushed through
    always_comb begin
        logic [7:0] t;
        t = state;
        if (augment)
            for (int i = 0; i < 8; i++) t = crc8_step(t, 1'b0);
        crc = t;
    end

endmodule

// File: rtl/joybus_cmd_rx.sv
// Joybus command receiver: pulse-width bit decode, command framing, address check, payload CRC.
module joybus_cmd_rx
    import joybus_pkg::*;
#(
    parameter int CLK_PER_US     = 4,
    parameter int PAYLOAD_BYTES  = 32,
    parameter int BIT_TIMEOUT_US = 6,
    parameter int IDLE_US        = 8
) (
    input logic              clk,
    input logic              reset_n,
    joybus_cmd_rx_if.master  bus
);

    localparam int MID     = 2 * CLK_PER_US;
    localparam int TOUT    = BIT_TIMEOUT_US * CLK_PER_US;
    localparam int IDLE_N  = IDLE_US * CLK_PER_US;
    localparam int TMAX    = (TOUT > IDLE_N) ? TOUT : IDLE_N;
    localparam int TW      = $clog2(TMAX + 1);
    localparam int MAXBITS = 24 + 8 * PAYLOAD_BYTES;
    localparam int CW      = $clog2(MAXBITS + 1);

    rx_state_e   state;
    logic        sync1, sync2, line_q;
    logic [TW-1:0] timer;
    logic [CW-1:0] bitcnt, explen;
    logic [15:0] sh;
    logic [7:0]  cmd_q, data_byte_q, data_crc_q;
    logic [15:0] address_q;
    logic        addr_seen, data_valid_q, tx_handoff_q, frame_error_q;
    logic        line, fall, sample, crc_en, crc_clr;
    logic [CW-1:0] bit_n;
    logic [7:0]  nbyte, crc;

    assign line   = sync2;
    assign fall   = line_q & ~sync2;
    assign sample = (timer == TW'(MID));
    assign bit_n  = bitcnt + 1'b1;
    assign nbyte  = {sh[6:0], line};

    assign crc_clr = ~bus.rx_enable | (state == ST_IDLE);
    assign crc_en  = bus.rx_enable & (state == ST_BIT_LOW) & sample & (bitcnt >= CW'(24));

    joybus_crc8 u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (crc_clr),
        .enable  (crc_en),
        .bit_in  (line),
        .augment (state == ST_STOP),
        .crc     (crc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_q <= 1'b1;
        end else begin
            sync1  <= bus.data_rx;
            sync2  <= sync1;
            line_q <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            timer         <= '0;
            bitcnt        <= '0;
            explen        <= CW'(MAXBITS);
            sh            <= '0;
            cmd_q         <= 8'hFE;
            address_q     <= '0;
            addr_seen     <= 1'b0;
            data_byte_q   <= '0;
            data_valid_q  <= 1'b0;
            data_crc_q    <= '0;
            tx_handoff_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            data_valid_q  <= 1'b0;
            tx_handoff_q  <= 1'b0;
            frame_error_q <= 1'b0;
            if (!bus.rx_enable) begin
                state  <= ST_IDLE;
                timer  <= '0;
                bitcnt <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (fall) begin
                            state  <= ST_BIT_LOW;
                            timer  <= '0;
                            bitcnt <= '0;
                        end
                    end
                    ST_BIT_LOW: begin
                        timer <= timer + 1'b1;
                        if (sample) begin
                            sh     <= {sh[14:0], line};
                            bitcnt <= bit_n;
                            state  <= ST_BIT_WAIT;
                            if (bit_n == CW'(8)) begin
                                cmd_q <= nbyte;
                                case (nbyte)
                                    CMD_INFO, CMD_STATUS, CMD_RESET: explen <= CW'(8);
                                    CMD_READ:  explen <= CW'(24);
                                    CMD_WRITE: explen <= CW'(MAXBITS);
                                    default: begin
                                        frame_error_q <= 1'b1;
                                        state         <= ST_DRAIN;
                                        timer         <= '0;
                                    end
                                endcase
                            end
                            if (bit_n == CW'(24)) begin
                                address_q <= {sh[14:0], line};
                                addr_seen <= 1'b1;
                            end
                            if (bit_n > CW'(24) && bit_n[2:0] == 3'b000) begin
                                data_byte_q  <= nbyte;
                                data_valid_q <= 1'b1;
                            end
                        end
                    end
                    ST_BIT_WAIT: begin
                        timer <= timer + 1'b1;
                        if (fall) begin
                            timer <= '0;
                            state <= (bitcnt == explen) ? ST_STOP : ST_BIT_LOW;
                        end else if (timer == TW'(TOUT)) begin
                            frame_error_q <= 1'b1;
                            state         <= ST_DRAIN;
                            timer         <= '0;
                        end
                    end
                    ST_STOP: begin
                        timer <= timer + 1'b1;
                        if (fall || (sample && !line)) begin
                            frame_error_q <= 1'b1;
                            state         <= ST_DRAIN;
                            timer         <= '0;
                        end else if (sample) begin
                            tx_handoff_q <= 1'b1;
                            state        <= ST_IDLE;
                            if (cmd_q == CMD_WRITE) data_crc_q <= crc;
                        end
                    end
                    ST_DRAIN: begin
                        if (!line)                         timer <= '0;
                        else if (timer == TW'(IDLE_N - 1)) state <= ST_IDLE;
                        else                               timer <= timer + 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.cmd         = cmd_q;
    assign bus.address     = address_q;
    assign bus.addr_ok     = addr_seen & addr_chk_ok(address_q);
    assign bus.data_byte   = data_byte_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.data_crc    = data_crc_q;
    assign bus.tx_handoff  = tx_handoff_q;
    assign bus.frame_error = frame_error_q;

endmodule
